// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO with power-of-two write/read width conversion, water-level
// flags, optional first-word-fall-through output stage and sticky error flags.
module sync_width_conv_fifo #(
  parameter int WR_DATA_WIDTH    = 8,
  parameter int RD_DATA_WIDTH    = 16,
  parameter int WR_DEPTH_WIDTH   = 12,
  parameter int ALMOST_FULL_NUM  = 2048,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int LITTLE_ENDIAN    = 1,
  parameter int FWFT             = 0,
  localparam int G = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
  localparam int RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + $clog2(WR_DATA_WIDTH / G)
                                  - $clog2(RD_DATA_WIDTH / G)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  output logic                      wr_full,
  output logic                      almost_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      wr_overflow,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_empty,
  output logic                      almost_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      rd_underflow,
  input  logic                      err_clr
);

  localparam int WR_UNITS  = WR_DATA_WIDTH / G;
  localparam int RD_UNITS  = RD_DATA_WIDTH / G;
  localparam int WR_LOG    = $clog2(WR_UNITS);
  localparam int RD_LOG    = $clog2(RD_UNITS);
  localparam int UNIT_AW   = WR_DEPTH_WIDTH + WR_LOG;
  localparam int C         = 1 << UNIT_AW;
  localparam int LANES     = (WR_UNITS > RD_UNITS) ? WR_UNITS : RD_UNITS;
  localparam int LANE_LOG  = $clog2(LANES);
  localparam int RAM_AW    = UNIT_AW - LANE_LOG;
  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int LW        = (LANE_LOG > 0) ? LANE_LOG : 1;
  localparam int PW        = UNIT_AW + 1;

  // Pointers address units modulo C; the occupancy counter tells full from empty.
  logic [UNIT_AW-1:0]       r_wrPtr;
  logic [UNIT_AW-1:0]       r_rdPtr;
  logic [PW-1:0]            r_cnt;
  logic [RD_DATA_WIDTH-1:0] r_rdData;
  logic                     r_outValid;
  logic                     r_overflow;
  logic                     r_underflow;

  logic                     w_wrFull;
  logic                     w_ramEmpty;
  logic                     w_rdEmpty;
  logic                     w_wrAccept;
  logic                     w_rdAccept;
  logic                     w_ramPop;
  logic [RAM_AW-1:0]        w_wrAddr;
  logic [RAM_AW-1:0]        w_rdAddr;
  logic [LW-1:0]            w_wrLane;
  logic [LW-1:0]            w_rdLane;
  logic [LANES-1:0]         w_laneWe;
  logic [G-1:0]             w_wrUnits [WR_UNITS];
  logic [G-1:0]             w_laneData [LANES];
  logic [RD_DATA_WIDTH-1:0] w_ramRdWord;

  assign w_wrAddr = RAM_AW'(r_wrPtr >> LANE_LOG);
  assign w_rdAddr = RAM_AW'(r_rdPtr >> LANE_LOG);
  assign w_wrLane = r_wrPtr[LW-1:0] & LW'(LANES - 1);
  assign w_rdLane = r_rdPtr[LW-1:0] & LW'(LANES - 1);

  assign w_wrFull   = r_cnt > PW'(C - WR_UNITS);
  assign w_ramEmpty = r_cnt < PW'(RD_UNITS);
  assign w_rdEmpty  = (FWFT != 0) ? !r_outValid : w_ramEmpty;
  assign w_wrAccept = wr_en && !w_wrFull;
  assign w_rdAccept = rd_en && !w_rdEmpty;
  assign w_ramPop   = (FWFT != 0) ? (!w_ramEmpty && (!r_outValid || w_rdAccept))
                                  : w_rdAccept;

  for (genvar j = 0; j < WR_UNITS; j++) begin : gWrSlice
    localparam int S = (LITTLE_ENDIAN != 0) ? j : WR_UNITS - 1 - j;
    assign w_wrUnits[j] = wr_data[S*G +: G];
  end

  // One G-bit memory per lane; a narrow write enables only its own lane.
  for (genvar k = 0; k < LANES; k++) begin : gLane
    logic [G-1:0] r_lane [RAM_DEPTH];
    assign w_laneWe[k]   = w_wrAccept && ((WR_UNITS == LANES) || (w_wrLane == LW'(k)));
    assign w_laneData[k] = r_lane[w_rdAddr];
    always_ff @(posedge clk) begin
      if (w_laneWe[k]) begin
        r_lane[w_wrAddr] <= w_wrUnits[k % WR_UNITS];
      end
    end
  end

  for (genvar j = 0; j < RD_UNITS; j++) begin : gRdSlice
    localparam int S = (LITTLE_ENDIAN != 0) ? j : RD_UNITS - 1 - j;
    assign w_ramRdWord[S*G +: G] = w_laneData[w_rdLane + LW'(j)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_cnt      <= '0;
      r_rdData   <= '0;
      r_outValid <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + UNIT_AW'(WR_UNITS);
      end
      if (w_ramPop) begin
        r_rdPtr  <= r_rdPtr + UNIT_AW'(RD_UNITS);
        r_rdData <= w_ramRdWord;
      end
      r_cnt <= r_cnt + (w_wrAccept ? PW'(WR_UNITS) : '0) - (w_ramPop ? PW'(RD_UNITS) : '0);
      if (FWFT != 0) begin
        if (w_ramPop) begin
          r_outValid <= 1'b1;
        end else if (w_rdAccept) begin
          r_outValid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_wrFull) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_rdEmpty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign wr_full        = w_wrFull;
  assign wr_water_level = (WR_DEPTH_WIDTH+1)'(r_cnt >> WR_LOG);
  assign almost_full    = wr_water_level >= (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  assign wr_overflow    = r_overflow;
  assign rd_data        = r_rdData;
  assign rd_empty       = w_rdEmpty;
  assign rd_water_level = (RD_DEPTH_WIDTH+1)'(r_cnt >> RD_LOG) + (RD_DEPTH_WIDTH+1)'(r_outValid);
  assign almost_empty   = rd_water_level <= (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  assign rd_underflow   = r_underflow;

endmodule
